// File: rtl/dff_scan_if.sv
// Host/chain signal bundle for dff_scan_ctrl: request and result on one side,
// the three scan pins plus chain clock enable on the other.
interface dff_scan_if #(
    parameter int CHAIN_LEN = 16
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pattern_in;
    logic                 scan_out;
    logic                 scan_en;
    logic                 scan_in;
    logic                 chain_ce;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] result;

    modport master (
        output start, pattern_in, scan_out,
        input  scan_en, scan_in, chain_ce, busy, done, result
    );

    modport slave (
        input  start, pattern_in, scan_out,
        output scan_en, scan_in, chain_ce, busy, done, result
    );
endinterface

// File: rtl/dff_scan_ctrl.sv
// Scan sequencer: loads a pattern into a flop chain, pulses functional capture,
// then unloads the captured state into result.
module dff_scan_ctrl #(
    parameter int CHAIN_LEN  = 16,
    parameter int CAP_CYCLES = 1
) (
    input logic       clk,
    input logic       reset,
    dff_scan_if.slave sif
);
    localparam int MAX_CNT = (CHAIN_LEN > CAP_CYCLES) ? CHAIN_LEN : CAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CAP   = CNT_W'(CAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic [CHAIN_LEN-1:0] result_q, result_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (sif.start) begin
                    shadow_d = sif.pattern_in;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // MSB goes out first so it travels furthest, ending in flop CHAIN_LEN-1
                shadow_d = {shadow_q[CHAIN_LEN-2:0], 1'b0};
                if (cnt_q == LAST_SHIFT) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                if (cnt_q == LAST_CAP) begin
                    cnt_d   = '0;
                    state_d = UNLOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UNLOAD: begin
                // scan_out is sampled on the same edge that advances the chain
                result_d = {result_q[CHAIN_LEN-2:0], sif.scan_out};
                if (cnt_q == LAST_SHIFT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sif.scan_en  = (state_q == SHIFT) || (state_q == UNLOAD);
    assign sif.chain_ce = (state_q == SHIFT) || (state_q == CAPTURE) || (state_q == UNLOAD);
    assign sif.scan_in  = (state_q == SHIFT) && shadow_q[CHAIN_LEN-1];
    assign sif.busy     = (state_q != IDLE);
    assign sif.done     = (state_q == DONE);
    assign sif.result   = result_q;
endmodule

// File: tb/tb_dff_scan_ctrl.sv
// Bench for dff_scan_ctrl: two controllers (1 and 3 capture cycles) each drive an
// 8-flop behavioural chain whose functional input is selectable (invert or shift-by-one).
module tb_dff_scan_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    logic shift_mode;
    logic [N-1:0] q0 = '0;
    logic [N-1:0] q1 = '0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dff_scan_if #(.CHAIN_LEN(N)) if0 ();
    dff_scan_if #(.CHAIN_LEN(N)) if1 ();

    dff_scan_ctrl #(.CHAIN_LEN(N), .CAP_CYCLES(1)) u0 (.clk(clk), .reset(reset), .sif(if0.slave));
    dff_scan_ctrl #(.CHAIN_LEN(N), .CAP_CYCLES(3)) u1 (.clk(clk), .reset(reset), .sif(if1.slave));

    assign if1.start      = if0.start;
    assign if1.pattern_in = if0.pattern_in;
    assign if0.scan_out   = q0[N-1];
    assign if1.scan_out   = q1[N-1];

    // Behavioural flop chains: scan shifts toward index N-1, capture applies d_i
    always @(posedge clk) begin
        if (if0.chain_ce)
            q0 <= if0.scan_en ? {q0[N-2:0], if0.scan_in} : (shift_mode ? {q0[N-2:0], 1'b0} : ~q0);
        if (if1.chain_ce)
            q1 <= if1.scan_en ? {q1[N-2:0], if1.scan_in} : (shift_mode ? {q1[N-2:0], 1'b0} : ~q1);
    end

    function automatic logic [N-1:0] ref_result(input logic [N-1:0] pat, input int caps, input logic sm);
        logic [N-1:0] v;
        v = pat;
        for (int i = 0; i < caps; i++) v = sm ? N'(v << 1) : ~v;
        return v;
    endfunction

    function automatic int ref_done_cycle(input int caps);
        return 2 * N + caps + 1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        if0.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Start is presented before edge 0 and dropped in cycle 1; returns in cycle 1.
    task automatic pulse_start(input logic [N-1:0] pat);
        @(negedge clk);
        if0.start = 1'b1;
        if0.pattern_in = pat;
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    // Counts cycles from the current one (=1) until done; -1 on timeout.
    task automatic wait_done(input bit which, output int cycles, output bit busy_ok);
        cycles = 1;
        busy_ok = 1'b1;
        forever begin
            if (!(which ? if1.busy : if0.busy)) busy_ok = 1'b0;
            if (which ? if1.done : if0.done) break;
            if (cycles >= 100) begin
                cycles = -1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({if0.busy, if0.done, if0.scan_en, if0.chain_ce, if0.scan_in} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000", {if0.busy, if0.done, if0.scan_en, if0.chain_ce, if0.scan_in});
        end
        n_tests++;
        if (if0.result !== 8'h00 || if1.result !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_result: got %h/%h required 00/00", if0.result, if1.result);
        end
    endtask

    task automatic test_basic();
        int c;
        bit b;
        do_reset();
        pulse_start(8'hA5);
        wait_done(1'b0, c, b);
        n_tests++;
        if (c !== ref_done_cycle(1)) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d required %0d", c, ref_done_cycle(1));
        end
        n_tests++;
        if (!b) begin
            n_fail++;
            $display("FAIL basic_busy: busy dropped before done, required high cycles 1..%0d", c);
        end
        n_tests++;
        if (if0.result !== ref_result(8'hA5, 1, 1'b0)) begin
            n_fail++;
            $display("FAIL basic_result: got %h required %h", if0.result, ref_result(8'hA5, 1, 1'b0));
        end
        @(negedge clk);
        n_tests++;
        if (if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.result !== 8'h5A) begin
            n_fail++;
            $display("FAIL basic_after: busy=%b done=%b result=%h required 0 0 5a", if0.busy, if0.done, if0.result);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        bit b;
        do_reset();
        pulse_start(8'h00);
        wait_done(1'b0, c, b);
        n_tests++;
        if (c !== ref_done_cycle(1) || if0.result !== ref_result(8'h00, 1, 1'b0)) begin
            n_fail++;
            $display("FAIL b2b_first: cycle=%0d result=%h required %0d %h", c, if0.result, ref_done_cycle(1), ref_result(8'h00, 1, 1'b0));
        end
        if0.start = 1'b1;
        if0.pattern_in = 8'hFF;
        @(negedge clk);
        n_tests++;
        if (if0.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ignored_in_done: busy=%b required 0", if0.busy);
        end
        @(negedge clk);
        if0.start = 1'b0;
        wait_done(1'b0, c, b);
        n_tests++;
        if (c !== ref_done_cycle(1) || !b || if0.result !== ref_result(8'hFF, 1, 1'b0)) begin
            n_fail++;
            $display("FAIL b2b_second: cycle=%0d busy_ok=%b result=%h required %0d 1 %h", c, b, if0.result, ref_done_cycle(1), ref_result(8'hFF, 1, 1'b0));
        end
    endtask

    task automatic test_shift_capture();
        int c;
        bit b;
        do_reset();
        shift_mode = 1'b1;
        pulse_start(8'h81);
        wait_done(1'b0, c, b);
        n_tests++;
        if (if0.result !== ref_result(8'h81, 1, 1'b1) || if0.result !== 8'h02) begin
            n_fail++;
            $display("FAIL shift_capture: got %h required 02", if0.result);
        end
        @(negedge clk);
        shift_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        int c;
        bit b;
        bit saw_done;
        do_reset();
        pulse_start(8'h96);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.result !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h required 0 0 00", if0.busy, if0.done, if0.result);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (if0.done || if0.busy) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: activity=%b required 0", saw_done);
        end
        pulse_start(8'h3C);
        wait_done(1'b0, c, b);
        n_tests++;
        if (c !== ref_done_cycle(1) || if0.result !== 8'hC3) begin
            n_fail++;
            $display("FAIL reset_mid_restart: cycle=%0d result=%h required %0d c3", c, if0.result, ref_done_cycle(1));
        end
    endtask

    task automatic test_busy_ignore();
        int c;
        bit b;
        logic [N-1:0] pat;
        do_reset();
        pat = N'($urandom);
        pulse_start(pat);
        @(negedge clk);
        if0.pattern_in = ~pat;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (8) @(negedge clk);
        if0.start = 1'b1;
        if0.pattern_in = N'($urandom);
        @(negedge clk);
        if0.start = 1'b0;
        wait_done(1'b0, c, b);
        n_tests++;
        if (c < 0 || c + 11 !== ref_done_cycle(1) || !b) begin
            n_fail++;
            $display("FAIL busy_ignore_timing: done cycle=%0d busy_ok=%b required %0d 1", c + 11, b, ref_done_cycle(1));
        end
        n_tests++;
        if (if0.result !== ref_result(pat, 1, 1'b0)) begin
            n_fail++;
            $display("FAIL busy_ignore_result: got %h required %h", if0.result, ref_result(pat, 1, 1'b0));
        end
    endtask

    task automatic test_cap3();
        int c;
        bit b;
        do_reset();
        pulse_start(8'hA5);
        wait_done(1'b1, c, b);
        n_tests++;
        if (c !== ref_done_cycle(3) || c !== 20 || !b) begin
            n_fail++;
            $display("FAIL cap3_latency: cycle=%0d busy_ok=%b required 20 1", c, b);
        end
        n_tests++;
        if (if1.result !== ref_result(8'hA5, 3, 1'b0)) begin
            n_fail++;
            $display("FAIL cap3_result: got %h required %h", if1.result, ref_result(8'hA5, 3, 1'b0));
        end
    endtask

    task automatic test_random();
        int c0, c1;
        bit b0, b1;
        logic [N-1:0] pat;
        logic [N-1:0] r0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            pat = N'($urandom);
            shift_mode = 1'($urandom_range(0, 1));
            pulse_start(pat);
            wait_done(1'b0, c0, b0);
            r0 = if0.result;
            @(negedge clk);
            wait_done(1'b1, c1, b1);
            n_tests++;
            if (c0 !== ref_done_cycle(1) || r0 !== ref_result(pat, 1, shift_mode) || !b0) begin
                n_fail++;
                $display("FAIL rand_cap1[%0d]: pat=%h mode=%b cycle=%0d result=%h required %0d %h", k, pat, shift_mode, c0, r0, ref_done_cycle(1), ref_result(pat, 1, shift_mode));
            end
            n_tests++;
            if (c1 < 0 || c0 + c1 !== ref_done_cycle(3) || if1.result !== ref_result(pat, 3, shift_mode)) begin
                n_fail++;
                $display("FAIL rand_cap3[%0d]: pat=%h mode=%b cycle=%0d result=%h required %0d %h", k, pat, shift_mode, c0 + c1, if1.result, ref_done_cycle(3), ref_result(pat, 3, shift_mode));
            end
            @(negedge clk);
        end
        shift_mode = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        shift_mode = 1'b0;
        if0.start = 1'b0;
        if0.pattern_in = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_shift_capture();
        test_reset_mid();
        test_busy_ignore();
        test_cap3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dff_scan_ctrl.md
Name: dff_scan_ctrl

Overview:
- Sequencer that drives a scan chain built from our reset-able D flip-flops: serially loads a test pattern, pulses a functional capture, then unloads the captured state.
- Used by the flip-flop characterisation harness so that a bank of DUT flops can be preset and observed through three pins (scan_en, scan_in, scan_out) plus a chain clock enable.
- Sits between the bench/host register interface (start/pattern/result) and the flop chain.

Parameters:
- CHAIN_LEN, 16, number of flops in the chain (>= 2).
- CAP_CYCLES, 1, number of functional capture cycles between load and unload (>= 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  request a load/capture/unload sequence; sampled only in IDLE.
- pattern_in  in  CHAIN_LEN  pattern to load; latched on accepted start.
- scan_out  in  1  serial output of the last chain flop (index CHAIN_LEN-1).
- scan_en  out  1  chain mux select: 1 = shift, 0 = functional d.
- scan_in  out  1  serial data into chain flop index 0.
- chain_ce  out  1  clock enable for the whole chain; 0 = chain holds.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result is valid.
- result  out  CHAIN_LEN  unloaded chain contents, result[i] = flop i after capture.

Behaviour:
- Reset: state = IDLE; scan_en, scan_in, chain_ce, busy, done = 0; result = 0; counter and pattern shadow = 0. Reset mid-sequence aborts immediately; the chain is left in whatever state it holds; no done pulse.
- States: IDLE, SHIFT, CAPTURE, UNLOAD, DONE. Outputs are Moore decodes of the state register plus shift registers; there is no combinational path from inputs to outputs.
- IDLE:
  - scan_en = 0, chain_ce = 0.
  - start = 1: latch pattern_in into the shadow register, set counter = 0, go to SHIFT.
- SHIFT, CHAIN_LEN cycles:
  - scan_en = 1, chain_ce = 1.
  - scan_in = shadow MSB; the shadow shifts left one bit per cycle.
  - After CHAIN_LEN shifts, flop i holds pattern_in[i]. When counter reaches CHAIN_LEN-1, clear counter and go to CAPTURE.
- CAPTURE, CAP_CYCLES cycles:
  - scan_en = 0, chain_ce = 1; the flops load their functional d.
  - When counter reaches CAP_CYCLES-1, clear counter and go to UNLOAD.
- UNLOAD, CHAIN_LEN cycles:
  - scan_en = 1, chain_ce = 1, scan_in = 0.
  - Each cycle, result shifts left with scan_out inserted at the LSB, sampled on the same edge that shifts the chain. The first sample is flop CHAIN_LEN-1, so after CHAIN_LEN samples result[i] = captured flop i.
  - When counter reaches CHAIN_LEN-1, go to DONE.
- DONE, 1 cycle:
  - done = 1, chain_ce = 0, scan_en = 0; then go to IDLE.
  - result holds its value until the next UNLOAD or reset.
- Latency: start accepted at edge 0. SHIFT covers cycles 1..N, CAPTURE N+1..N+C, UNLOAD N+C+1..2N+C, done at cycle 2N+C+1. busy is high for cycles 1..2N+C+1.
- start while busy is ignored. start in the same cycle as done is ignored; it is accepted on the following IDLE cycle.
- pattern_in changes after acceptance have no effect on the sequence in progress.
- Counter width is $clog2(max(CHAIN_LEN, CAP_CYCLES)+1); the counter never wraps past its terminal count.

Test Plan:
- Setup for all scenarios: CHAIN_LEN=8, CAP_CYCLES=1; the bench chain is 8 flops with functional d_i = ~q_i.
- Reset, then start with pattern_in=8'hA5 -> result=8'h5A, done pulses exactly 18 cycles after the start edge, busy high for those 18 cycles.
- Pattern 8'h00, then 8'hFF, back-to-back: second start asserted in the done cycle and held -> accepted one cycle later; results 8'hFF then 8'h00.
- Bench chain with functional d_i = q_(i-1), d_0 = 0 (shift by one on capture); pattern 8'h81 -> result 8'h02.
- Reset asserted during UNLOAD (cycle 12) -> next cycle IDLE, busy=0, done never pulses, result=0; a fresh start with 8'h3C then returns 8'hC3.
- start pulsed while busy, and pattern_in changed mid-SHIFT -> ignored; result reflects only the originally latched pattern.
- CAP_CYCLES=3 with the inverting chain, pattern 8'hA5 -> three captures give 8'h5A; done at cycle 2*8+3+1 = 20.
